// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: state encoding,
// default bundle widths and control-bit positions.
package pipe_pkg;

  localparam int CTRL_W_DEF = 9;
  localparam int DATA_W_DEF = 111;

  // Control bundle bit positions, shared by every stage that packs/unpacks it
  localparam int ALUSRC   = 0;
  localparam int REGDST   = 1;
  localparam int MEMREAD  = 2;
  localparam int MEMWRITE = 3;
  localparam int REGWRITE = 4;
  localparam int MEMTOREG = 5;
  localparam int ALUOP_LO = 6;
  localparam int ALUOP_HI = 8;

  // Encoding doubles as the occupancy count
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stage_entry.sv
// One stage entry: valid flag, control bundle and data bundle.
// load captures a new entry; clr retires it, zeroing ctrl so a bubble
// never carries live control bits. Data is left as-is on clr.
module pipe_stage_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Entry register; load wins over clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ctrl_d;
      data  <= data_d;
    end else if (clr) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, a skid entry so
// in_ready can be registered without losing throughput, and a
// synchronous flush that leaves a bubble.
//
//   state | meaning
//   ------+-------------------------------------------
//   EMPTY | nothing held, out_valid=0
//   HALF  | main entry valid, skid empty
//   FULL  | main and skid valid, in_ready=0
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  state_t state_q, state_n;
  logic   in_ready_q;
  logic   push, pop;

  logic              main_load, main_clr, skid_load, skid_clr;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] main_data, skid_data, main_data_d;

  assign push = in_valid & in_ready_q;
  assign pop  = main_valid & out_ready;

  // The skid entry is only valid in FULL, so it is the older entry whenever
  // main is refilled while it holds something.
  assign main_ctrl_d = skid_valid ? skid_ctrl : in_ctrl;
  assign main_data_d = skid_valid ? skid_data : in_data;

  // Next state and entry controls; flush overrides any push/pop
  always_comb begin
    state_n   = state_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      state_n  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_load = 1'b1;
            state_n   = HALF;
          end
        end
        HALF: begin
          if (push && !pop) begin
            skid_load = 1'b1;
            state_n   = FULL;
          end else if (push && pop) begin
            main_load = 1'b1;
          end else if (pop) begin
            main_clr = 1'b1;
            state_n  = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_load = 1'b1;
            skid_clr  = 1'b1;
            state_n   = HALF;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
          state_n  = EMPTY;
        end
      endcase
    end
  end

  // State and registered in_ready; in_ready never depends on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_n;
      in_ready_q <= (state_n != FULL);
    end
  end

  pipe_stage_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (main_load),
    .clr    (main_clr),
    .ctrl_d (main_ctrl_d),
    .data_d (main_data_d),
    .valid  (main_valid),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  pipe_stage_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_load),
    .clr    (skid_clr),
    .ctrl_d (in_ctrl),
    .data_d (in_data),
    .valid  (skid_valid),
    .ctrl   (skid_ctrl),
    .data   (skid_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  // Ctrl is already cleared on retire; the gate keeps bubbles inert regardless
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = state_q;

endmodule
